seq_alu: RTL

Parametrised, multi-cycle successor to the single-cycle ALU for the co-processor datapath.
- add/sub complete in one cycle.
- mul is a shift-add multiplier and div is a restoring divider; each runs one bit per clock, WIDTH cycles total.
- mul returns a full 2*WIDTH product, where the current ALU truncates it.
- Adds a busy/ready handshake, carry/borrow output and error flagging (divide-by-zero, illegal opcode).

---
 rtl/seq_alu_pkg.sv | 19 +
 rtl/seq_muldiv_core.sv | 78 +++++++
 rtl/seq_alu.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM encoding and sizing helper for the sequential ALU.
package seq_alu_pkg;

   localparam logic [7:0] OP_ADD = 8'h01;
   localparam logic [7:0] OP_SUB = 8'h02;
   localparam logic [7:0] OP_MUL = 8'h03;
   localparam logic [7:0] OP_DIV = 8'h04;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Step counter must hold WIDTH itself, hence WIDTH+1 codes.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider, one bit per clock.
module seq_muldiv_core
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int unsigned CW = cnt_width(WIDTH);

   logic [CW-1:0]    r_cnt;
   logic             r_is_div;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_b;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0] w_q_nxt;

   // r_acc/r_q form one 2*WIDTH shift register: product for mul, remainder/quotient for div.
   always_comb begin
      w_sum     = {1'b0, r_acc} + {1'b0, {WIDTH{r_q[0]}} & r_b};
      w_shift   = {r_acc, r_q[WIDTH-1]};
      w_diff    = w_shift[WIDTH-1:0] - r_b;
      w_acc_nxt = r_acc;
      w_q_nxt   = r_q;
      if (r_is_div) begin
         if (w_shift >= {1'b0, r_b}) begin
            w_acc_nxt = w_diff;
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
         end else begin
            w_acc_nxt = w_shift[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         {w_acc_nxt, w_q_nxt} = {w_sum, r_q[WIDTH-1:1]};
      end
   end

   // Done is asserted combinationally during the final step so the parent
   // registers the finished result on that same edge.
   assign o_done = (r_cnt == CW'(1));
   assign o_hi   = r_is_div ? w_q_nxt   : w_acc_nxt;
   assign o_lo   = r_is_div ? w_acc_nxt : w_q_nxt;

   always_ff @(posedge i_clk) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_acc    <= '0;
         r_q      <= '0;
         r_b      <= '0;
      end else if (i_start) begin
         r_cnt    <= CW'(WIDTH);
         r_is_div <= i_is_div;
         r_acc    <= '0;
         r_q      <= i_a;
         r_b      <= i_b;
      end else if (r_cnt != '0) begin
         r_cnt    <= r_cnt - CW'(1);
         r_acc    <= w_acc_nxt;
         r_q      <= w_q_nxt;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub, iterative mul/div, error flagging.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter logic [7:0]  OP_ADD = seq_alu_pkg::OP_ADD,
   parameter logic [7:0]  OP_SUB = seq_alu_pkg::OP_SUB,
   parameter logic [7:0]  OP_MUL = seq_alu_pkg::OP_MUL,
   parameter logic [7:0]  OP_DIV = seq_alu_pkg::OP_DIV
) (
   input  logic             i_clk,
   input  logic             reset,
   input  logic             i_ready,
   input  logic [WIDTH-1:0] i_num_1,
   input  logic [WIDTH-1:0] i_num_2,
   input  logic [7:0]       op_code,
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_err,
   output logic [WIDTH-1:0] result_Hi,
   output logic [WIDTH-1:0] result_Lo
);

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_ready;
   logic             r_err;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_start;
   logic             w_is_div;
   logic             w_cmpl;
   logic             w_err_nxt;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic             w_core_done;
   logic [WIDTH-1:0] w_core_hi;
   logic [WIDTH-1:0] w_core_lo;

   seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
      .i_clk    (i_clk),
      .reset    (reset),
      .i_start  (w_start),
      .i_is_div (w_is_div),
      .i_a      (i_num_1),
      .i_b      (i_num_2),
      .o_done   (w_core_done),
      .o_hi     (w_core_hi),
      .o_lo     (w_core_lo)
   );

   always_ff @(posedge i_clk) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start)     w_state_nxt = BUSY;
         BUSY:    if (w_core_done) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_add     = {1'b0, i_num_1} + {1'b0, i_num_2};
      w_sub     = {1'b0, i_num_1} - {1'b0, i_num_2};
      w_start   = 1'b0;
      w_is_div  = (op_code == OP_DIV);
      w_cmpl    = 1'b0;
      w_err_nxt = 1'b0;
      w_hi_nxt  = '0;
      w_lo_nxt  = '0;
      o_busy    = (r_state == BUSY);
      case (r_state)
         IDLE: if (i_ready) begin
            w_cmpl = 1'b1;
            if (op_code == OP_ADD) begin
               w_hi_nxt = WIDTH'(w_add[WIDTH]);
               w_lo_nxt = w_add[WIDTH-1:0];
            end else if (op_code == OP_SUB) begin
               w_hi_nxt = WIDTH'(w_sub[WIDTH]);
               w_lo_nxt = w_sub[WIDTH-1:0];
            end else if (op_code == OP_MUL) begin
               w_cmpl  = 1'b0;
               w_start = 1'b1;
            end else if (op_code == OP_DIV) begin
               if (i_num_2 == '0) begin
                  w_hi_nxt  = '1;
                  w_lo_nxt  = i_num_1;
                  w_err_nxt = 1'b1;
               end else begin
                  w_cmpl  = 1'b0;
                  w_start = 1'b1;
               end
            end else begin
               w_err_nxt = 1'b1;
            end
         end
         BUSY: if (w_core_done) begin
            w_cmpl   = 1'b1;
            w_hi_nxt = w_core_hi;
            w_lo_nxt = w_core_lo;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!reset) begin
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_ready <= w_cmpl;
         if (w_cmpl) begin
            r_err <= w_err_nxt;
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
         end
      end
   end

   assign o_ready   = r_ready;
   assign o_err     = r_err;
   assign result_Hi = r_hi;
   assign result_Lo = r_lo;

endmodule
